alu_secuencial: RTL and testbench

- Next-generation ALU for the single-cycle processor datapath, parametrised in width N.
- Adds registered NZCV flags, XOR and shift operations, and iterative multi-cycle MUL and DIV.
- Uses a start/busy/done handshake so the control unit can stall while a multi-cycle operation runs.
- Operands are captured on start, so the datapath may change a/b freely while the block is busy.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_secuencial_if.sv | 31 +++
 rtl/alu_muldiv_seq.sv | 86 ++++++++
 rtl/alu_secuencial.sv | 155 +++++++++++++++
 tb/tb_alu_secuencial.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and control FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_SHR = 4'b0110,
        OP_MUL = 4'b0111,
        OP_DIV = 4'b1000
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, EXEC, CALC, DONE} alu_state_t;

endpackage

// File: rtl/alu_secuencial_if.sv
// Request/response bundle between the control unit (master) and the sequential ALU (slave).
interface alu_secuencial_if #(parameter int N = 4);

    // start is taken only while the ALU is idle and its operands are captured on that edge;
    // busy covers every following cycle through done, and done is a one-cycle pulse after
    // which result, result_hi and the flags stay valid until the next done.
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic [3:0]   selec_alu;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic         f_N;
    logic         f_Z;
    logic         f_C;
    logic         f_V;

    modport master (
        output start, a, b, ci, selec_alu,
        input  busy, done, result, result_hi, f_N, f_Z, f_C, f_V
    );

    modport slave (
        input  start, a, b, ci, selec_alu,
        output busy, done, result, result_hi, f_N, f_Z, f_C, f_V
    );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative engine: shift-add multiply, and restoring divide when ALU_DIV_EN is defined.
// N iterations after load, then fin is held for one cycle with {hi, lo} final.
module alu_muldiv_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         is_div,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi,
    output logic         fin
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  lo_q, hi_q, b_q, lo_d, hi_d;
    logic [N:0]    sum;
    logic          run_q, start_ok;
    logic [CW-1:0] cnt_q;

`ifdef ALU_DIV_EN
    logic          div_q;
    logic [N:0]    tmp;
    logic [N-1:0]  diff;
    logic          ge;

    assign start_ok = load;
`else
    // Without a divider a divide request cannot be serviced here.
    assign start_ok = load & ~is_div;
`endif

    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
        hi_d = sum[N:1];
        lo_d = {sum[0], lo_q[N-1:1]};
`ifdef ALU_DIV_EN
        // Remainder in hi, dividend shifting out of lo while quotient bits shift in.
        tmp  = {hi_q, lo_q[N-1]};
        ge   = (tmp >= {1'b0, b_q});
        diff = tmp[N-1:0] - b_q;
        if (div_q) begin
            hi_d = ge ? diff : tmp[N-1:0];
            lo_d = {lo_q[N-2:0], ge};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q  <= '0;
            hi_q  <= '0;
            b_q   <= '0;
            run_q <= 1'b0;
            cnt_q <= '0;
`ifdef ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start_ok) begin
            lo_q  <= a;
            hi_q  <= '0;
            b_q   <= b;
            run_q <= 1'b1;
            cnt_q <= '0;
`ifdef ALU_DIV_EN
            div_q <= is_div;
`endif
        end else if (run_q) begin
            if (cnt_q == CW'(N)) begin
                run_q <= 1'b0;
            end else begin
                lo_q  <= lo_d;
                hi_q  <= hi_d;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign lo  = lo_q;
    assign hi  = hi_q;
    assign fin = run_q && (cnt_q == CW'(N));

endmodule

// File: rtl/alu_secuencial.sv
// Sequential ALU with registered NZCV flags and start/busy/done control; the divide
// operation exists only when ALU_DIV_EN is defined, otherwise it is an illegal op.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_secuencial_if.slave   bus,
    output alu_state_t        dbg_state
);

    localparam int SHW = $clog2(N);

    alu_state_t     state_q, state_d;
    logic [3:0]     op_q;
    logic [N-1:0]   a_q, b_q;
    logic           ci_q;
    logic           accept, is_mc_in, is_div_in, upd;
    logic [N-1:0]   eng_lo, eng_hi, res_d, res_hi_d;
    logic           eng_fin, c_d, v_d;
    logic [N:0]     wide;
    logic [SHW-1:0] sh;
    logic [N-1:0]   result_q, result_hi_q;
    logic           fn_q, fz_q, fc_q, fv_q;

    assign accept = (state_q == IDLE) && bus.start;
`ifdef ALU_DIV_EN
    assign is_div_in = (bus.selec_alu == OP_DIV);
`else
    assign is_div_in = 1'b0;
`endif
    assign is_mc_in = (bus.selec_alu == OP_MUL) || is_div_in;

    alu_muldiv_seq #(.N(N)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept && is_mc_in),
        .is_div (is_div_in),
        .a      (bus.a),
        .b      (bus.b),
        .lo     (eng_lo),
        .hi     (eng_hi),
        .fin    (eng_fin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ci_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= bus.selec_alu;
                a_q  <= bus.a;
                b_q  <= bus.b;
                ci_q <= bus.ci;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = is_mc_in ? CALC : EXEC;
            EXEC:    state_d = DONE;
            CALC:    if (eng_fin) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result/C/V candidates; illegal codes fall through to zero, which yields Z=1.
    always_comb begin
        res_d    = '0;
        res_hi_d = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        wide     = '0;
        sh       = b_q[SHW-1:0];
        if (state_q == CALC) begin
            res_d    = eng_lo;
            res_hi_d = eng_hi;
`ifdef ALU_DIV_EN
            v_d = (op_q == OP_DIV) ? (b_q == '0) : (eng_hi != '0);
`else
            v_d = (eng_hi != '0);
`endif
        end else begin
            case (op_q)
                OP_ADD: begin
                    wide  = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, ci_q};
                    res_d = wide[N-1:0];
                    c_d   = wide[N];
                    v_d   = (a_q[N-1] == b_q[N-1]) && (res_d[N-1] != a_q[N-1]);
                end
                OP_SUB: begin
                    wide  = {1'b0, a_q} - {1'b0, b_q} - {{N{1'b0}}, ci_q};
                    res_d = wide[N-1:0];
                    c_d   = ~wide[N];
                    v_d   = (a_q[N-1] != b_q[N-1]) && (res_d[N-1] != a_q[N-1]);
                end
                OP_AND: res_d = a_q & b_q;
                OP_OR:  res_d = a_q | b_q;
                OP_XOR: res_d = a_q ^ b_q;
                OP_SHL: begin
                    wide  = {1'b0, a_q} << sh;
                    res_d = wide[N-1:0];
                    c_d   = wide[N];
                end
                OP_SHR: begin
                    wide  = {a_q, 1'b0} >> sh;
                    res_d = wide[N:1];
                    c_d   = wide[0];
                end
                default: ;
            endcase
        end
    end

    assign upd = (state_q == EXEC) || ((state_q == CALC) && eng_fin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            fn_q        <= 1'b0;
            fz_q        <= 1'b0;
            fc_q        <= 1'b0;
            fv_q        <= 1'b0;
        end else if (upd) begin
            result_q    <= res_d;
            result_hi_q <= res_hi_d;
            fn_q        <= res_d[N-1];
            fz_q        <= (res_d == '0);
            fc_q        <= c_d;
            fv_q        <= v_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.f_N       = fn_q;
    assign bus.f_Z       = fz_q;
    assign bus.f_C       = fc_q;
    assign bus.f_V       = fv_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Scoreboard bench for alu_secuencial (N=4): directed vectors, expected responses queued at issue.
module tb_alu_secuencial;
    import alu_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    alu_state_t dbg_state;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    // {expected done cycle[15:0], result[3:0], result_hi[3:0], nzcv[3:0]}
    logic [27:0] exp_q[$];
    string       name_q[$];

    alu_secuencial_if #(.N(N)) bus ();

    alu_secuencial #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: every done pulse must match the head of the expected queue
    always @(negedge clk) begin
        logic [27:0] e;
        string       nm;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_result"}, 32'(bus.result), 32'(e[11:8]));
                check({nm, "_result_hi"}, 32'(bus.result_hi), 32'(e[7:4]));
                check({nm, "_nzcv"}, 32'({bus.f_N, bus.f_Z, bus.f_C, bus.f_V}), 32'(e[3:0]));
                check({nm, "_done_cycle"}, 32'(cyc), 32'(e[27:12]));
            end
        end
    end

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check({nm, "_timeout"}, 32'(seen), 32'd1);
    endtask

    // early=1: called on a done cycle, start is raised while the FSM is leaving DONE
    task automatic issue(input string nm, input logic [3:0] op, input logic [3:0] aa,
                         input logic [3:0] bb, input logic cc, input logic [3:0] er,
                         input logic [3:0] eh, input logic [3:0] ef, input int lat,
                         input bit early);
        int c;
        if (!early) @(negedge clk);
        c = early ? cyc + 1 : cyc;
        bus.start     = 1'b1;
        bus.selec_alu = op;
        bus.a         = aa;
        bus.b         = bb;
        bus.ci        = cc;
        exp_q.push_back({16'(c + lat), er, eh, ef});
        name_q.push_back(nm);
        @(negedge clk);
        if (early) @(negedge clk);
        bus.start = 1'b0;
        wait_done(nm);
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, "_busy"}, 32'(bus.busy), 32'd0);
        check({nm, "_done"}, 32'(bus.done), 32'd0);
        check({nm, "_result"}, 32'(bus.result), 32'd0);
        check({nm, "_result_hi"}, 32'(bus.result_hi), 32'd0);
        check({nm, "_nzcv"}, 32'({bus.f_N, bus.f_Z, bus.f_C, bus.f_V}), 32'd0);
        check({nm, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int  c;
        bit  seen;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.selec_alu = '0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        issue("add_wrap",  4'b0000, 4'b0111, 4'b1001, 1'b0, 4'b0000, 4'b0000, 4'b0110, 2, 1'b0);
        issue("sub_neg",   4'b0001, 4'b0011, 4'b0101, 1'b0, 4'b1110, 4'b0000, 4'b1000, 2, 1'b0);
        issue("add_ovf",   4'b0000, 4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0000, 4'b1001, 2, 1'b0);
        issue("add_ci",    4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0110, 2, 1'b0);
        issue("sub_ci",    4'b0001, 4'b0101, 4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b0010, 2, 1'b0);
        issue("sub_ovf",   4'b0001, 4'b1000, 4'b0001, 1'b0, 4'b0111, 4'b0000, 4'b0011, 2, 1'b0);
        issue("and",       4'b0010, 4'b1100, 4'b1010, 1'b0, 4'b1000, 4'b0000, 4'b1000, 2, 1'b0);
        issue("or",        4'b0011, 4'b1100, 4'b1010, 1'b0, 4'b1110, 4'b0000, 4'b1000, 2, 1'b0);
        issue("xor",       4'b0100, 4'b1100, 4'b1010, 1'b0, 4'b0110, 4'b0000, 4'b0000, 2, 1'b0);
        issue("illegal",   4'b1111, 4'b1100, 4'b1010, 1'b1, 4'b0000, 4'b0000, 4'b0100, 2, 1'b0);
        issue("shl1",      4'b0101, 4'b1011, 4'b0001, 1'b0, 4'b0110, 4'b0000, 4'b0010, 2, 1'b0);
        issue("add_early", 4'b0000, 4'b0001, 4'b0010, 1'b0, 4'b0011, 4'b0000, 4'b0000, 2, 1'b1);
        issue("shl3",      4'b0101, 4'b1011, 4'b0011, 1'b0, 4'b1000, 4'b0000, 4'b1010, 2, 1'b0);
        issue("shr2",      4'b0110, 4'b1011, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0010, 2, 1'b0);
        issue("mul_small", 4'b0111, 4'b0011, 4'b0010, 1'b0, 4'b0110, 4'b0000, 4'b0000, 6, 1'b0);

        // MUL with a start (and operand change) while busy that must be ignored
        @(negedge clk);
        c             = cyc;
        bus.start     = 1'b1;
        bus.selec_alu = 4'b0111;
        bus.a         = 4'b1101;
        bus.b         = 4'b1011;
        exp_q.push_back({16'(c + 6), 4'b1111, 4'b1000, 4'b1001});
        name_q.push_back("mul_big");
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 3) begin
                bus.start     = 1'b1;
                bus.selec_alu = 4'b0000;
                bus.a         = 4'b0001;
                bus.b         = 4'b0001;
            end
            if (k == 4) bus.start = 1'b0;
            check("mul_busy", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check("mul_idle_after", 32'(bus.busy), 32'd0);

`ifdef ALU_DIV_EN
        issue("div",       4'b1000, 4'b1110, 4'b0011, 1'b0, 4'b0100, 4'b0010, 4'b0000, 6, 1'b0);
        issue("div_zero",  4'b1000, 4'b1001, 4'b0000, 1'b0, 4'b1111, 4'b1001, 4'b1001, 6, 1'b0);
        issue("div_exact", 4'b1000, 4'b0111, 4'b0111, 1'b0, 4'b0001, 4'b0000, 4'b0000, 6, 1'b0);
`else
        issue("div_off",   4'b1000, 4'b1110, 4'b0011, 1'b0, 4'b0000, 4'b0000, 4'b0100, 2, 1'b0);
        issue("div0_off",  4'b1000, 4'b1001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 2, 1'b0);
`endif
        issue("shr0",      4'b0110, 4'b1011, 4'b0000, 1'b0, 4'b1011, 4'b0000, 4'b1000, 2, 1'b0);

        // reset two cycles into a MUL: everything clears at once, no done follows
        @(negedge clk);
        bus.start     = 1'b1;
        bus.selec_alu = 4'b0111;
        bus.a         = 4'b1101;
        bus.b         = 4'b1011;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("mid_reset_no_done", 32'(seen), 32'd0);

        issue("add_after_rst", 4'b0000, 4'b0010, 4'b0011, 1'b0, 4'b0101, 4'b0000, 4'b0000, 2, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
